// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port CPU register file with a sequenced bulk-clear engine.
//
// Port A carries ALU/normal writeback and port B carries load/multiply writeback.
// Each write port has its own per-byte enables. When both ports hit the same entry
// in the same cycle their bytes are merged, and port B wins on bytes that both
// ports enable. A clear request sweeps every entry to zero, one entry per cycle.
// Writes are refused (wr_ready=0) while the sweep runs and during its done cycle.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   we_x/waddr_x/wdata_x/wbe_x write port x (x = a, b)
//   raddr / rdata              NUM_RD packed combinational read ports
//   clr_req                    bulk-clear request, sampled in IDLE only
//   clr_busy / clr_done        sweep in progress / one-cycle completion pulse
//   wr_ready                   writes are accepted only while high
//
// Build option: REGFILE_BYPASS_EN enables write-first forwarding. A read that
// matches a write accepted in the same cycle returns the merged next value.
// Without it, reads are read-first and there is no wdata->rdata path.
//
// Clear FSM:
//   state   | meaning
//   S_IDLE  | normal operation, writes accepted
//   S_CLEAR | zeroing entry ptr_q each cycle, DEPTH cycles total
//   S_DONE  | one-cycle clr_done pulse, writes still blocked
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        waddr_a,
  input  logic [DATA_W-1:0]        wdata_a,
  input  logic [DATA_W/8-1:0]      wbe_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        waddr_b,
  input  logic [DATA_W-1:0]        wdata_b,
  input  logic [DATA_W/8-1:0]      wbe_b,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_a, acc_b;
  logic [DEPTH-1:0]  hit_a, hit_b;

  assign wr_ready = (state_q == S_IDLE);
  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = (state_q == S_DONE);

  // With a hardwired zero register, a write to entry 0 is never accepted. That keeps
  // mem_q[0] at zero, so it also never shows up as a forwarded value.
  assign acc_a = we_a & wr_ready & ~((ZERO_REG != 0) & (waddr_a == '0));
  assign acc_b = we_b & wr_ready & ~((ZERO_REG != 0) & (waddr_b == '0));
  assign hit_a = acc_a ? (DEPTH'(1) << waddr_a) : '0;
  assign hit_b = acc_b ? (DEPTH'(1) << waddr_b) : '0;

  // Byte merge: B over A over the stored value.
  function automatic logic [DATA_W-1:0] merge_fn(
    input logic [DATA_W-1:0] old_v,
    input logic              use_a,
    input logic [DATA_W-1:0] d_a,
    input logic [BE_W-1:0]   be_a,
    input logic              use_b,
    input logic [DATA_W-1:0] d_b,
    input logic [BE_W-1:0]   be_b
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < BE_W; b++) begin
      if (use_b && be_b[b])      r[b*8 +: 8] = d_b[b*8 +: 8];
      else if (use_a && be_a[b]) r[b*8 +: 8] = d_a[b*8 +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr_req) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
          end
        end
        S_CLEAR: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == ADDR_W'(DEPTH - 1)) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The sweep and normal writes never overlap, because hit_a/hit_b are zero
  // outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_busy && (ptr_q == ADDR_W'(i))) begin
          mem_q[i] <= '0;
        end else if (hit_a[i] || hit_b[i]) begin
          mem_q[i] <= merge_fn(mem_q[i], hit_a[i], wdata_a, wbe_a,
                               hit_b[i], wdata_b, wbe_b);
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      ra = raddr[k*ADDR_W +: ADDR_W];
      rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      rv = merge_fn(rv, hit_a[ra], wdata_a, wbe_a, hit_b[ra], wdata_b, wbe_b);
`endif
      if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
      rdata[k*DATA_W +: DATA_W] = rv;
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port CPU register file: 2 write ports, NUM_RD combinational read ports, per-byte write enables, optional hardwired zero register.
- Adds a sequenced bulk-clear engine with a busy/done handshake and write back-pressure.
- Sits in the decode/writeback stage of the CPU datapath. Port A carries ALU/normal writeback; port B carries the second writeback path (load/multiply).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports, range 1..4.
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- we_a  in  1  write enable, port A.
- waddr_a  in  ADDR_W  write address, port A.
- wdata_a  in  DATA_W  write data, port A.
- wbe_a  in  DATA_W/8  byte enables, port A; bit i covers wdata_a[8i+7:8i].
- we_b, waddr_b, wdata_b, wbe_b  in  1/ADDR_W/DATA_W/DATA_W/8  same fields for port B.
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port k = raddr[k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  packed read data; port k = rdata[k*DATA_W +: DATA_W].
- clr_req  in  1  bulk-clear request; sampled in IDLE only.
- clr_busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse after the final entry is cleared.
- wr_ready  out  1  writes are accepted only when high.

Behaviour:
- Reset (rst=1, asynchronous):
  - All DEPTH entries = 0; FSM = IDLE; clear pointer = 0.
  - clr_busy = 0, clr_done = 0, wr_ready = 1; all rdata = 0.
  - Reset mid-sweep aborts the sweep; no clr_done pulse is produced.
- Write commit, port A: on posedge when we_a & wr_ready.
  - Only bytes with wbe_a[i]=1 are updated; other bytes hold.
  - wbe = 0 is a no-op.
- Write commit, port B: same rules with we_b/wbe_b.
- Same address on both ports, same cycle:
  - Bytes are merged; for bytes enabled on both ports, port B data wins.
- Writes with wr_ready=0 are dropped silently; the producer must hold its request.
- ZERO_REG=1:
  - Writes to address 0 are ignored on both ports.
  - Every read of address 0 returns 0.
- Reads are combinational from the array.
  - Without the bypass feature, a read returns the pre-edge value (read-first).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: wr_ready=1. clr_req=1 -> CLEAR next cycle with ptr=0. Writes committed in the same cycle clr_req is sampled still take effect.
  - CLEAR: clr_busy=1, wr_ready=0. Each posedge writes 0 to entry ptr and increments ptr. When ptr==DEPTH-1 that entry is cleared -> DONE.
  - CLEAR occupies exactly DEPTH cycles.
  - DONE: clr_done=1 for exactly one cycle, wr_ready=0 -> IDLE.
  - clr_req in CLEAR/DONE is ignored (not queued).
  - clr_busy and clr_done are Moore outputs decoded from the state register.
  - wr_ready = (state==IDLE).
- Reads during CLEAR return current contents: already-swept entries read 0, unswept entries keep their old value.
- ptr is ADDR_W bits and wraps naturally; it is reset to 0 on entry to CLEAR.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding. When a read address matches a write accepted in the same cycle, rdata returns the merged next value in that cycle.
  - Merge uses byte enables, with B over A over stored data.
  - ZERO_REG still forces address 0 to 0.
  - No forwarding during CLEAR, since no writes are accepted then.
- Not defined: rdata always reflects stored contents (read-first). No combinational path from wdata to rdata.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rdata=0; wr_ready=1, clr_busy=0, clr_done=0.
- Port A writes 0xDEADBEEF to r5 with wbe=4'b1111; next cycle port A writes 0x000000AA with wbe=4'b0001 -> r5 reads 0xDEADBEAA.
- Same cycle: A writes r7=0x11111111 (wbe 4'b1111), B writes r7=0x22222222 (wbe 4'b0011) -> r7=0x11112222. Also write r0=0xFFFFFFFF -> r0 reads 0.
- Fill r1..r31 with their index; pulse clr_req -> clr_busy high for 32 cycles, clr_done pulses once; write attempted mid-sweep is dropped; afterwards all entries read 0.
- Assert rst at sweep cycle 10 -> immediate all-zero; FSM IDLE; no clr_done; wr_ready=1.
- With REGFILE_BYPASS_EN: write r3=0x12345678 while raddr0=3 -> rdata0=0x12345678 in the same cycle. Without the macro: old value in that cycle, new value next cycle.
